// File: rtl/bcd_pkg.sv
// Shared BCD conversion constants and the state encoding used by the BCD/binary converters.
package bcd_pkg;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_ADJUST     = 3'd2,
        ST_ITERATE    = 3'd3,
        ST_LAST_SHIFT = 3'd4,
        ST_DONE       = 3'd5
    } bcd_state_t;

    localparam logic [2:0] ITER_LIMIT        = 3'd6;  // shift/adjust passes before the final shift
    localparam logic [3:0] DIGIT_THRESH      = 4'd8;  // digit value that needs correcting
    localparam logic [3:0] CORR_CONST        = 4'd3;  // correction applied to such a digit
    localparam int         DEFAULT_DONE_HOLD = 24;

    // A BCD digit holding 10..15 is not a decimal digit.
    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit correction step for reverse double-dabble: digits >= 8 lose 3.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    // Combinational correction; digits below threshold pass through.
    always_comb begin
        digit_adj = digit;
        if (digit >= DIGIT_THRESH)
            digit_adj = digit - CORR_CONST;
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Two-digit BCD to 7-bit binary converter (reverse double-dabble, one step per cycle).
// Optional macro BCD2BIN_ERR_EN: reject non-decimal digits straight to DONE with out_ERR=1.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DONE_HOLD = DEFAULT_DONE_HOLD
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_init,
    input  logic [3:0] in_DEC,
    input  logic [3:0] in_UND,
    output logic [6:0] out_BIN,
    output logic       out_BUSY,
    output logic       out_DONE,
    output logic       out_ERR
);

    localparam int TW = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;

    // Working register {tens, units, binary}: digits drain into the binary field.
    bcd_state_t     state, state_n;
    logic [2:0]     cnt, cnt_n;
    logic [TW-1:0]  timer, timer_n;
    logic [14:0]    sr, sr_n;
    logic [1:0][3:0] dig, dig_adj;

    assign dig = sr[14:7];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dig
            bcd_digit_sub3 u_sub3 (
                .digit     (dig[g]),
                .digit_adj (dig_adj[g])
            );
        end
    endgenerate

`ifdef BCD2BIN_ERR_EN
    logic err, err_n;
    assign out_ERR = err;
`else
    assign out_ERR = 1'b0;
`endif

    // State and datapath registers; reset wins from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_START;
            cnt   <= '0;
            timer <= TW'(DONE_HOLD);
            sr    <= '0;
`ifdef BCD2BIN_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            timer <= timer_n;
            sr    <= sr_n;
`ifdef BCD2BIN_ERR_EN
            err   <= err_n;
`endif
        end
    end

    // Next-state and datapath control; unused encodings fall into the START branch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        timer_n = timer;
        sr_n    = sr;
`ifdef BCD2BIN_ERR_EN
        err_n   = err;
`endif
        case (state)
            ST_SHIFT: begin
                sr_n    = {1'b0, sr[14:1]};
                state_n = ST_ADJUST;
            end
            ST_ADJUST: begin
                sr_n    = {dig_adj, sr[6:0]};
                state_n = ST_ITERATE;
            end
            ST_ITERATE: begin
                cnt_n   = cnt + 3'd1;
                state_n = (cnt_n == ITER_LIMIT) ? ST_LAST_SHIFT : ST_SHIFT;
            end
            ST_LAST_SHIFT: begin
                sr_n    = {1'b0, sr[14:1]};
                state_n = ST_DONE;
            end
            ST_DONE: begin
                if (timer == '0) begin
                    // Clear on exit so START shows a zero result.
                    sr_n    = '0;
                    state_n = ST_START;
`ifdef BCD2BIN_ERR_EN
                    err_n   = 1'b0;
`endif
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = ST_START;
                cnt_n   = '0;
                timer_n = TW'(DONE_HOLD);
                sr_n    = '0;
`ifdef BCD2BIN_ERR_EN
                err_n   = 1'b0;
                if (in_init && (digit_invalid(in_DEC) || digit_invalid(in_UND))) begin
                    err_n   = 1'b1;
                    state_n = ST_DONE;
                end else
`endif
                if (in_init) begin
                    sr_n    = {in_DEC, in_UND, 7'b0};
                    state_n = ST_SHIFT;
                end
            end
        endcase
    end

    assign out_BIN  = sr[6:0];
    assign out_DONE = (state == ST_DONE);
    assign out_BUSY = (state == ST_SHIFT) || (state == ST_ADJUST) ||
                      (state == ST_ITERATE) || (state == ST_LAST_SHIFT);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin; expectations come from 10*DEC+UND and the timing rules.
// Latency is counted in rising edges with the accepting edge as edge 1.
module tb_bcd_to_bin;

    localparam int HOLD    = 24;
    localparam int LAT_OK  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_init;
    logic [3:0] in_DEC, in_UND;
    logic [6:0] out_BIN;
    logic       out_BUSY, out_DONE, out_ERR;

    int vectors = 0;
    int errors  = 0;

    bcd_to_bin #(.DONE_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_init  (in_init),
        .in_DEC   (in_DEC),
        .in_UND   (in_UND),
        .out_BIN  (out_BIN),
        .out_BUSY (out_BUSY),
        .out_DONE (out_DONE),
        .out_ERR  (out_ERR)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_bin(input int d, input int u);
        return 7'(10 * d + u);
    endfunction

    // Drive one conversion and measure it; all checking is left to the caller.
    task automatic do_conv(input logic [3:0] d, input logic [3:0] u, input bit toggle, input bit hold,
                           output int lat, output logic [6:0] bin, output logic err,
                           output int width, output bit stable,
                           output logic post_busy, output logic post_done, output logic [6:0] post_bin);
        in_DEC  = d;
        in_UND  = u;
        in_init = 1'b1;
        lat     = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_DONE) begin
                lat = n;
                break;
            end
            if (!hold) in_init = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            if (toggle) begin
                in_DEC = 4'($urandom);
                in_UND = 4'($urandom);
            end
        end
        in_init = hold;
        bin     = out_BIN;
        err     = out_ERR;
        width   = 0;
        stable  = 1'b1;
        if (lat > 0) begin
            width = 1;
            for (int k = 0; k < 200; k++) begin
                @(posedge clk); #1;
                if (!out_DONE) break;
                width++;
                if (out_BIN !== bin || out_ERR !== err) stable = 1'b0;
            end
        end
        post_busy = out_BUSY;
        post_done = out_DONE;
        post_bin  = out_BIN;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_init = 1'b0; in_DEC = 4'd0; in_UND = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (out_BIN !== 7'd0)  begin errors++; $display("FAIL reset_bin got %0d want 0", out_BIN); end
        if (out_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", out_BUSY); end
        if (out_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", out_DONE); end
        if (out_ERR !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", out_ERR); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int d_tab[3] = '{4, 9, 0};
        int u_tab[3] = '{2, 9, 0};
        int lat, width; logic [6:0] bin, pb; logic err, pbusy, pdone; bit st;
        for (int i = 0; i < 3; i++) begin
            do_conv(4'(d_tab[i]), 4'(u_tab[i]), 1'b0, 1'b0, lat, bin, err, width, st, pbusy, pdone, pb);
            vectors += 6;
            if (lat !== LAT_OK) begin errors++; $display("FAIL dir_lat %0d%0d got %0d want %0d", d_tab[i], u_tab[i], lat, LAT_OK); end
            if (bin !== ref_bin(d_tab[i], u_tab[i])) begin errors++; $display("FAIL dir_bin got %0d want %0d", bin, ref_bin(d_tab[i], u_tab[i])); end
            if (err !== 1'b0) begin errors++; $display("FAIL dir_err got %b want 0", err); end
            if (width !== HOLD + 1) begin errors++; $display("FAIL dir_width got %0d want %0d", width, HOLD + 1); end
            if (!st) begin errors++; $display("FAIL dir_stable got unstable want stable"); end
            if (pbusy !== 1'b0 || pdone !== 1'b0 || pb !== 7'd0) begin
                errors++; $display("FAIL dir_idle got busy=%b done=%b bin=%0d want 0/0/0", pbusy, pdone, pb);
            end
        end
    endtask

    task automatic test_sweep();
        int order[100];
        int lat, width, j, t; logic [6:0] bin, pb; logic err, pbusy, pdone; bit st;
        for (int i = 0; i < 100; i++) order[i] = i;
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 100; i++) begin
            do_conv(4'(order[i] / 10), 4'(order[i] % 10), 1'b0, 1'b0, lat, bin, err, width, st, pbusy, pdone, pb);
            vectors += 4;
            if (bin !== 7'(order[i])) begin errors++; $display("FAIL sweep_bin %0d got %0d want %0d", order[i], bin, order[i]); end
            if (lat !== LAT_OK) begin errors++; $display("FAIL sweep_lat %0d got %0d want %0d", order[i], lat, LAT_OK); end
            if (width !== HOLD + 1) begin errors++; $display("FAIL sweep_width %0d got %0d want %0d", order[i], width, HOLD + 1); end
            if (err !== 1'b0 || !st) begin errors++; $display("FAIL sweep_err %0d got err=%b stable=%b want 0/1", order[i], err, st); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, width, d, u; logic [6:0] bin, pb; logic err, pbusy, pdone; bit st;
        in_DEC = 4'd7; in_UND = 4'd5; in_init = 1'b1;
        @(posedge clk); #1;
        in_init = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors += 1;
        if (out_BUSY !== 1'b0 || out_DONE !== 1'b0 || out_BIN !== 7'd0 || out_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outs got busy=%b done=%b bin=%0d err=%b want 0/0/0/0", out_BUSY, out_DONE, out_BIN, out_ERR);
        end
        d = $urandom_range(0, 9); u = $urandom_range(0, 9);
        do_conv(4'(d), 4'(u), 1'b0, 1'b0, lat, bin, err, width, st, pbusy, pdone, pb);
        vectors += 2;
        if (bin !== ref_bin(d, u)) begin errors++; $display("FAIL rstmid_bin got %0d want %0d", bin, ref_bin(d, u)); end
        if (lat !== LAT_OK) begin errors++; $display("FAIL rstmid_lat got %0d want %0d", lat, LAT_OK); end
    endtask

    task automatic test_invalid();
        int lat, width, d, u, exp_lat; logic [6:0] bin, pb; logic err, pbusy, pdone, exp_err; bit st;
`ifdef BCD2BIN_ERR_EN
        exp_lat = 1;  exp_err = 1'b1;
`else
        exp_lat = LAT_OK; exp_err = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin d = 10; u = 3; end
            else if (i % 2 == 1) begin d = $urandom_range(10, 15); u = $urandom_range(0, 15); end
            else begin d = $urandom_range(0, 9); u = $urandom_range(10, 15); end
            do_conv(4'(d), 4'(u), 1'b0, 1'b0, lat, bin, err, width, st, pbusy, pdone, pb);
            vectors += 3;
            if (lat !== exp_lat) begin errors++; $display("FAIL inv_lat d=%0d u=%0d got %0d want %0d", d, u, lat, exp_lat); end
            if (err !== exp_err) begin errors++; $display("FAIL inv_err d=%0d u=%0d got %b want %b", d, u, err, exp_err); end
            if (width !== HOLD + 1) begin errors++; $display("FAIL inv_width got %0d want %0d", width, HOLD + 1); end
`ifdef BCD2BIN_ERR_EN
            vectors += 1;
            if (bin !== 7'd0) begin errors++; $display("FAIL inv_bin got %0d want 0", bin); end
`endif
        end
    endtask

    task automatic test_ignore();
        int lat, width, d, u; logic [6:0] bin, pb; logic err, pbusy, pdone; bit st;
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 9); u = $urandom_range(0, 9);
            do_conv(4'(d), 4'(u), 1'b1, 1'b0, lat, bin, err, width, st, pbusy, pdone, pb);
            vectors += 3;
            if (bin !== ref_bin(d, u)) begin errors++; $display("FAIL ign_bin got %0d want %0d", bin, ref_bin(d, u)); end
            if (lat !== LAT_OK) begin errors++; $display("FAIL ign_lat got %0d want %0d", lat, LAT_OK); end
            if (width !== HOLD + 1) begin errors++; $display("FAIL ign_width got %0d want %0d", width, HOLD + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, width, d, u; logic [6:0] bin, pb; logic err, pbusy, pdone; bit st;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 9); u = $urandom_range(0, 9);
            do_conv(4'(d), 4'(u), 1'b0, (i < 3), lat, bin, err, width, st, pbusy, pdone, pb);
            vectors += 4;
            if (bin !== ref_bin(d, u)) begin errors++; $display("FAIL b2b_bin %0d got %0d want %0d", i, bin, ref_bin(d, u)); end
            // A latency of exactly LAT_OK here means the preceding START lasted one cycle.
            if (lat !== LAT_OK) begin errors++; $display("FAIL b2b_lat %0d got %0d want %0d", i, lat, LAT_OK); end
            if (width !== HOLD + 1) begin errors++; $display("FAIL b2b_width %0d got %0d want %0d", i, width, HOLD + 1); end
            if (pbusy !== 1'b0 || pdone !== 1'b0) begin errors++; $display("FAIL b2b_start %0d got busy=%b done=%b want 0/0", i, pbusy, pdone); end
        end
        in_init = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_reset_mid();
        test_invalid();
        test_ignore();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DONE_HOLD, default 24: extra cycles out_DONE stays high after its first DONE cycle.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_init  input  1  start request, sampled only in START.
REQ-005 SHALL have port in_DEC  input  4  BCD tens digit, sampled on the accepting edge.
REQ-006 SHALL have port in_UND  input  4  BCD units digit, sampled on the accepting edge.
REQ-007 SHALL have port out_BIN  output  7  binary result, 10*DEC+UND; valid while out_DONE=1.
REQ-008 SHALL have port out_BUSY  output  1  high in every state except START and DONE.
REQ-009 SHALL have port out_DONE  output  1  high only in state DONE.
REQ-010 SHALL have port out_ERR  output  1  invalid-digit flag, valid while out_DONE=1.

Function
REQ-011 SHALL use reverse double-dabble on a 15-bit register {DEC[3:0], UND[3:0], BIN[6:0]}: shift right 1, then subtract 3 from each BCD digit >= 8.
REQ-012 SHALL implement states START, SHIFT, ADJUST, ITERATE, LAST_SHIFT, DONE; unused encodings SHALL behave as START.
REQ-013 START: register {in_DEC, in_UND, 7'b0} loaded when in_init=1, otherwise cleared to 0; in_init=1 -> SHIFT, else stay.
REQ-014 SHIFT -> ADJUST: whole register shifted right 1, MSB filled with 0.
REQ-015 ADJUST -> ITERATE: each digit field >= 8 reduced by 3 in the same cycle; fields < 8 unchanged; both fields may adjust together.
REQ-016 ITERATE: 3-bit iteration counter incremented; counter reaching 6 -> LAST_SHIFT, else -> SHIFT.
REQ-017 LAST_SHIFT -> DONE: seventh and final right shift, no adjust.
REQ-018 Latency: DONE SHALL be entered exactly 20 cycles after the edge that accepts in_init (6x SHIFT/ADJUST/ITERATE + LAST_SHIFT).
REQ-019 DONE SHALL hold for DONE_HOLD+1 cycles, then return to START; the timer SHALL reload on every START cycle.
REQ-020 out_BIN SHALL equal register bits [6:0] and SHALL stay stable for the whole DONE period.
REQ-021 in_init asserted outside START SHALL be ignored; in_DEC/in_UND SHALL NOT be resampled during a conversion.
REQ-022 in_init held high through DONE SHALL start a new conversion on the first START cycle after DONE.

Reset
REQ-023 rst=1 SHALL force START, counter 0, timer DONE_HOLD and register 0 on the next edge, from any state including mid-conversion.
REQ-024 While in START: out_BIN=0, out_BUSY=0, out_DONE=0, out_ERR=0.

Configuration
REQ-025 With macro BCD2BIN_ERR_EN defined: a digit > 9 at the accepting edge SHALL send START directly to DONE with out_ERR=1, out_BIN=0, no SHIFT cycles, full DONE_HOLD period.
REQ-026 Without BCD2BIN_ERR_EN: no digit check; out_ERR SHALL be constant 0; out_BIN for digits > 9 is unspecified but the timing SHALL be unchanged.

Structure
REQ-027 Package bcd_pkg SHALL hold the state encodings, iteration limit (6), digit threshold (8), correction constant (3) and default DONE_HOLD, shared with the binary-to-BCD converter.
REQ-028 The per-digit ">= 8 then minus 3" logic SHALL be a combinational sub-module bcd_digit_sub3, instantiated twice.

Verification
REQ-029 DEC=4, UND=2, in_init pulse -> out_DONE rises 20 cycles later, out_BIN=42 (0101010), out_ERR=0.
REQ-030 DEC=9, UND=9 -> out_BIN=99 (1100011); DEC=0, UND=0 -> out_BIN=0; latency 20 in both cases.
REQ-031 Sweep all 100 valid pairs -> out_BIN=10*DEC+UND for each; out_DONE high exactly 25 cycles with default DONE_HOLD.
REQ-032 rst pulsed at cycle 10 of a conversion -> START on next edge, all outputs 0; a new in_init then converts correctly.
REQ-033 BCD2BIN_ERR_EN defined, DEC=10, UND=3 -> DONE on the next edge, out_ERR=1, out_BIN=0; macro undefined -> out_ERR stays 0, DONE after 20 cycles.
REQ-034 in_init toggled and digits changed during BUSY -> result unaffected; in_init held high -> back-to-back conversions separated by exactly one START cycle.
